// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus controller: FSM state
// encoding, the ack-mode wait marker and the default device address map.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // A wait count of all ones means "wait for the device acknowledge".
    localparam logic [3:0] WAIT_ACK = 4'hF;

    // Default map: base / compare mask per device.
    localparam logic [7:0] RAM_BASE     = 8'h00;
    localparam logic [7:0] RAM_MASK     = 8'h80;
    localparam logic [7:0] PERIPH0_BASE = 8'h80;
    localparam logic [7:0] PERIPH0_MASK = 8'hE0;
    localparam logic [7:0] PERIPH1_BASE = 8'hA0;
    localparam logic [7:0] PERIPH1_MASK = 8'hE0;
    localparam logic [7:0] PERIPH2_BASE = 8'hC0;
    localparam logic [7:0] PERIPH2_MASK = 8'hF0;

    // Width of a device index for n devices (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_region_decode.sv
// Purely combinational address decoder: compares the address against every
// device region and returns a priority one-hot select (lowest index wins),
// the index of the winning region and a hit flag.
module region_decode
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int N_DEV      = 4,
    parameter int IDX_W      = 2
) (
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic [N_DEV*ADDR_WIDTH-1:0] base_i,
    input  logic [N_DEV*ADDR_WIDTH-1:0] mask_i,
    output logic [N_DEV-1:0]            sel_o,
    output logic [IDX_W-1:0]            idx_o,
    output logic                        hit_o
);

    logic [N_DEV-1:0] match_s;
    logic [N_DEV-1:0] sel_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Region compare plus priority pick; a region only wins if no lower one matched.
    always_comb begin
        match_s = '0;
        sel_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            match_s[i] = ((addr_i & mask_i[i*ADDR_WIDTH +: ADDR_WIDTH])
                          == base_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
            sel_s[i]   = match_s[i] & ~found_s;
            idx_s      = idx_s | ({IDX_W{sel_s[i]}} & IDX_W'(i));
            found_s    = found_s | match_s[i];
        end
    end

    assign sel_o = sel_s;
    assign idx_o = idx_s;
    assign hit_o = found_s;

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: decodes CPU reads/writes onto one of N_DEV devices,
// times the access with a fixed wait count or a device acknowledge (with
// timeout), and returns registered read data plus a ready/error pulse.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int                          DATA_WIDTH = 8,
    parameter int                          ADDR_WIDTH = 8,
    parameter int                          N_DEV      = 4,
    parameter logic [N_DEV*ADDR_WIDTH-1:0] DEV_BASE   = {PERIPH2_BASE, PERIPH1_BASE,
                                                         PERIPH0_BASE, RAM_BASE},
    parameter logic [N_DEV*ADDR_WIDTH-1:0] DEV_MASK   = {PERIPH2_MASK, PERIPH1_MASK,
                                                         PERIPH0_MASK, RAM_MASK},
    parameter logic [N_DEV*4-1:0]          DEV_WAIT   = {WAIT_ACK, 4'd2, 4'd1, 4'd0},
    parameter int                          TIMEOUT    = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic                        req_rd,
    input  logic                        req_wr,
    output logic                        req_ready,
    output logic                        req_err,
    output logic [DATA_WIDTH-1:0]       req_rdata,
    output logic                        busy,
    output logic [N_DEV-1:0]            dev_sel,
    output logic [ADDR_WIDTH-1:0]       dev_addr,
    output logic [DATA_WIDTH-1:0]       dev_wdata,
    output logic                        dev_rd,
    output logic                        dev_wr,
    input  logic [N_DEV*DATA_WIDTH-1:0] dev_rdata,
    input  logic [N_DEV-1:0]            dev_ack
);

    localparam int         IDX_W   = idx_width(N_DEV);
    // Last counter value an ack-mode access may reach before timing out.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q;
    logic [7:0]             cnt_q;
    logic [IDX_W-1:0]       sel_idx_q;
    logic [3:0]             wait_q;
    logic                   is_rd_q;
    logic                   req_ready_q;
    logic                   req_err_q;
    logic [DATA_WIDTH-1:0]  req_rdata_q;
    logic [N_DEV-1:0]       dev_sel_q;
    logic [ADDR_WIDTH-1:0]  dev_addr_q;
    logic [DATA_WIDTH-1:0]  dev_wdata_q;
    logic                   dev_rd_q;
    logic                   dev_wr_q;

    logic [N_DEV-1:0]       dec_sel_s;
    logic [IDX_W-1:0]       dec_idx_s;
    logic                   dec_hit_s;
    logic [3:0]             dec_wait_s;
    logic                   cur_ack_s;
    logic [DATA_WIDTH-1:0]  cur_rdata_s;

    region_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .N_DEV      (N_DEV),
        .IDX_W      (IDX_W)
    ) u_region_decode (
        .addr_i (req_addr),
        .base_i (DEV_BASE),
        .mask_i (DEV_MASK),
        .sel_o  (dec_sel_s),
        .idx_o  (dec_idx_s),
        .hit_o  (dec_hit_s)
    );

    // Per-device lookups: wait count of the decoded device, and ack / read
    // data of the device latched for the access in progress.
    assign dec_wait_s  = DEV_WAIT[dec_idx_s*4 +: 4];
    assign cur_ack_s   = dev_ack[sel_idx_q];
    assign cur_rdata_s = dev_rdata[sel_idx_q*DATA_WIDTH +: DATA_WIDTH];

    // Bus FSM: request acceptance, access timing, completion and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            sel_idx_q   <= '0;
            wait_q      <= 4'd0;
            is_rd_q     <= 1'b0;
            req_ready_q <= 1'b0;
            req_err_q   <= 1'b0;
            req_rdata_q <= '0;
            dev_sel_q   <= '0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_rd_q    <= 1'b0;
            dev_wr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 8'd0;
                    if (req_rd && req_wr) begin
                        // Conflicting request: report it without touching any device.
                        state_q     <= ST_RESP;
                        req_ready_q <= 1'b1;
                        req_err_q   <= 1'b1;
                        req_rdata_q <= '0;
                    end else if (req_rd || req_wr) begin
                        if (dec_hit_s) begin
                            state_q     <= ST_ACCESS;
                            dev_sel_q   <= dec_sel_s;
                            dev_addr_q  <= req_addr;
                            dev_wdata_q <= req_wdata;
                            dev_rd_q    <= req_rd;
                            dev_wr_q    <= req_wr;
                            is_rd_q     <= req_rd;
                            sel_idx_q   <= dec_idx_s;
                            wait_q      <= dec_wait_s;
                        end else begin
                            state_q     <= ST_RESP;
                            req_ready_q <= 1'b1;
                            req_err_q   <= 1'b1;
                            req_rdata_q <= '0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_ACCESS: begin
                    cnt_q    <= cnt_q + 8'd1;
                    // Write strobe lasts only the first access cycle.
                    dev_wr_q <= 1'b0;
                    if (wait_q == WAIT_ACK) begin
                        // Ack beats timeout when both land in the same cycle.
                        if (cur_ack_s) begin
                            state_q     <= ST_RESP;
                            req_ready_q <= 1'b1;
                            req_err_q   <= 1'b0;
                            req_rdata_q <= is_rd_q ? cur_rdata_s : req_rdata_q;
                            dev_rd_q    <= 1'b0;
                            dev_sel_q   <= '0;
                        end else if (cnt_q == TO_LAST) begin
                            state_q     <= ST_RESP;
                            req_ready_q <= 1'b1;
                            req_err_q   <= 1'b1;
                            req_rdata_q <= '0;
                            dev_rd_q    <= 1'b0;
                            dev_sel_q   <= '0;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end else if (cnt_q == {4'd0, wait_q}) begin
                        state_q     <= ST_RESP;
                        req_ready_q <= 1'b1;
                        req_err_q   <= 1'b0;
                        req_rdata_q <= is_rd_q ? cur_rdata_s : req_rdata_q;
                        dev_rd_q    <= 1'b0;
                        dev_sel_q   <= '0;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end

                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    req_err_q   <= 1'b0;
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    req_err_q   <= 1'b0;
                    dev_sel_q   <= '0;
                    dev_rd_q    <= 1'b0;
                    dev_wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign req_rdata = req_rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign dev_sel   = dev_sel_q;
    assign dev_addr  = dev_addr_q;
    assign dev_wdata = dev_wdata_q;
    assign dev_rd    = dev_rd_q;
    assign dev_wr    = dev_wr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with default parameters. Stimulus pushes
// the expected completion (cycle, err, rdata, strobe activity) computed from
// the address-map rules; a monitor pops and compares on every req_ready.
module tb_mem_bus_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req_addr = 8'h00;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_ready, req_err, busy, dev_rd, dev_wr;
    logic [7:0]  req_rdata, dev_addr, dev_wdata;
    logic [3:0]  dev_sel;
    logic [31:0] dev_rdata;
    logic [3:0]  dev_ack = 4'b0000;
    logic [7:0]  rdv [4];

    assign dev_rdata = {rdv[3], rdv[2], rdv[1], rdv[0]};

    mem_bus_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .busy      (busy),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_rd    (dev_rd),
        .dev_wr    (dev_wr),
        .dev_rdata (dev_rdata),
        .dev_ack   (dev_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference address map, written as plain tables.
    int ref_base [4] = '{8'h00, 8'h80, 8'hA0, 8'hC0};
    int ref_mask [4] = '{8'h80, 8'hE0, 8'hE0, 8'hF0};
    int ref_wait [4] = '{0, 1, 2, -1};   // -1: acknowledge-driven

    typedef struct {
        int         cyc;
        logic       err;
        logic       chk_rd;
        logic [7:0] rdata;
        logic [3:0] sel;
        int         wr_cnt;
        int         rd_cnt;
        logic       chk_wd;
        logic [7:0] wdata;
        logic       chk_addr;
        logic [7:0] addr;
    } exp_t;

    exp_t       sb [$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_known = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic int ref_decode(input logic [7:0] a);
        for (int i = 0; i < 4; i++)
            if ((int'(a) & ref_mask[i]) == ref_base[i]) return i;
        return -1;
    endfunction

    // Push the expected completion of one request sampled at the end of cycle c.
    task automatic expect_txn(input logic [7:0] a, input bit rd, input bit wr,
                              input logic [7:0] wd, input int k, input int c, output int lat);
        exp_t e;
        int   idx;
        idx = ref_decode(a);
        e = '{cyc: 0, err: 1'b0, chk_rd: 1'b0, rdata: 8'h00, sel: 4'h0, wr_cnt: 0,
              rd_cnt: 0, chk_wd: 1'b0, wdata: 8'h00, chk_addr: 1'b0, addr: 8'h00};
        if (rd && wr) begin
            lat = 1; e.err = 1'b1; m_known = 1'b0;
        end else if (idx < 0) begin
            lat = 1; e.err = 1'b1; m_rdata = 8'h00; m_known = 1'b1;
            e.chk_rd = 1'b1; e.rdata = 8'h00;
        end else begin
            e.sel = 4'(1 << idx); e.chk_addr = 1'b1; e.addr = a;
            if (wr) begin e.wr_cnt = 1; e.chk_wd = 1'b1; e.wdata = wd; end
            if (ref_wait[idx] < 0) begin
                if (k >= 1 && k <= TIMEOUT) lat = k + 1;
                else begin lat = TIMEOUT + 1; e.err = 1'b1; end
            end else begin
                lat = ref_wait[idx] + 2;
            end
            if (rd) e.rd_cnt = lat - 1;
            if (e.err) begin m_rdata = 8'h00; m_known = 1'b1; end
            else if (rd) begin m_rdata = rdv[idx]; m_known = 1'b1; end
            e.chk_rd = m_known; e.rdata = m_rdata;
        end
        e.cyc = c + lat;
        sb.push_back(e);
    endtask

    // Issue one request (called just after a falling edge); k is the access
    // cycle in which the ack device answers; hold keeps req_rd up for a second access.
    task automatic run_txn(input logic [7:0] a, input bit rd, input bit wr,
                           input logic [7:0] wd, input int k, input bit hold);
        int c, lat, lat2, total;
        c = cyc;
        req_addr = a; req_wdata = wd; req_rd = rd; req_wr = wr;
        expect_txn(a, rd, wr, wd, k, c, lat);
        if (hold) expect_txn(a, rd, wr, wd, k, c + lat + 1, lat2);
        total = hold ? (2 * lat + 1) : lat;
        for (int n = 1; n <= total + 1; n++) begin
            @(negedge clk);
            if ((!hold && n == 1) || (hold && n == lat + 2)) begin
                req_rd = 1'b0; req_wr = 1'b0;
            end
            dev_ack = {(n == k) && !hold, 3'($urandom_range(0, 7))};
            if (n == 1) chk("busy_after_accept", busy, 1'b1);
        end
        dev_ack = 4'b0000;
        chk("busy_idle_after", busy, 1'b0);
    endtask

    // Monitor: collect strobe activity per transaction, compare on each completion.
    int         wr_seen = 0;
    int         rd_seen = 0;
    logic [3:0] sel_seen = 4'h0;
    logic [7:0] wd_seen = 8'h00;
    logic [7:0] ad_seen = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            wr_seen = 0; rd_seen = 0; sel_seen = 4'h0;
        end else begin
            if (dev_wr) begin wr_seen++; wd_seen = dev_wdata; end
            if (dev_rd) rd_seen++;
            sel_seen = sel_seen | dev_sel;
            if (dev_sel != 4'h0) ad_seen = dev_addr;
            if (req_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ready_cycle", cyc, e.cyc);
                    chk("req_err", req_err, e.err);
                    if (e.chk_rd) chk("req_rdata", req_rdata, e.rdata);
                    chk("dev_sel", sel_seen, e.sel);
                    chk("dev_wr_cycles", wr_seen, e.wr_cnt);
                    chk("dev_rd_cycles", rd_seen, e.rd_cnt);
                    if (e.chk_wd) chk("dev_wdata", wd_seen, e.wdata);
                    if (e.chk_addr) chk("dev_addr", ad_seen, e.addr);
                end
                wr_seen = 0; rd_seen = 0; sel_seen = 4'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r, a, k;
        for (int i = 0; i < 4; i++) rdv[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_req_err", req_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {dev_rd, dev_wr}, 2'b00);
        chk("rst_dev_sel", dev_sel, 4'h0);
        chk("rst_req_rdata", req_rdata, 8'h00);
        chk("rst_dev_addr", dev_addr, 8'h00);
        chk("rst_dev_wdata", dev_wdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        rdv[0] = 8'h3C;
        run_txn(8'h05, 1'b1, 1'b0, 8'h00, 0, 1'b0);      // RAM read, W=0
        run_txn(8'hA4, 1'b0, 1'b1, 8'h5A, 0, 1'b0);      // PERIPH1 write, W=2
        run_txn(8'hE0, 1'b1, 1'b0, 8'h00, 0, 1'b0);      // unmapped
        rdv[3] = 8'h96;
        run_txn(8'hC3, 1'b1, 1'b0, 8'h00, 3, 1'b0);      // ack on 3rd access cycle
        run_txn(8'hC3, 1'b1, 1'b0, 8'h00, 99, 1'b0);     // timeout
        run_txn(8'hC3, 1'b1, 1'b0, 8'h00, 15, 1'b0);     // ack on the timeout cycle
        run_txn(8'h10, 1'b1, 1'b1, 8'h00, 0, 1'b0);      // rd+wr together

        // Reset during ACCESS of a W=2 read.
        rdv[2] = 8'h77;
        req_addr = 8'hA1; req_rd = 1'b1;
        @(negedge clk); req_rd = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_strobes", {dev_rd, dev_wr}, 2'b00);
        chk("abort_dev_sel", dev_sel, 4'h0);
        chk("abort_ready", req_ready, 1'b0);
        chk("abort_rdata", req_rdata, 8'h00);
        @(negedge clk); rst = 1'b0;
        m_rdata = 8'h00; m_known = 1'b1;
        @(negedge clk);
        chk("abort_no_ready", req_ready, 1'b0);
        rdv[0] = 8'hE1;
        run_txn(8'h7F, 1'b1, 1'b0, 8'h00, 0, 1'b0);      // clean read after reset
        rdv[1] = 8'h4B;
        run_txn(8'h84, 1'b1, 1'b0, 8'h00, 0, 1'b1);      // held request, W=1

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 4; i++) rdv[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 255);
            k = $urandom_range(1, 18);
            if (r == 0)
                run_txn(8'(a), 1'b1, 1'b1, 8'($urandom), k, 1'b0);
            else if (r <= 4)
                run_txn(8'(a), 1'b0, 1'b1, 8'($urandom), k, 1'b0);
            else if (r == 9 && ref_decode(8'(a)) >= 0 && ref_wait[ref_decode(8'(a))] >= 0)
                run_txn(8'(a), 1'b1, 1'b0, 8'h00, k, 1'b1);
            else
                run_txn(8'(a), 1'b1, 1'b0, 8'h00, k, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
